// File: rtl/slsu_pkg.sv
// Load/store unit shared types.
// States, fault codes and funct3 encodings.
package slsu_pkg;

  localparam int LSU_DW = 32;
  localparam int LSU_MEM_BYTES = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_BOUNDS   = 2'b10,
    FLT_ILLEGAL  = 2'b11
  } lsu_fault_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
    logic [4:0] rd;
  } lsu_req_t;

endpackage

// File: rtl/slsu_if.sv
// Execute-stage request/response and
// data memory control bundle.
interface slsu_if #(
  parameter int DW = 32
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_store_i;
  logic [2:0]    req_funct3_i;
  logic [DW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [4:0]    req_rd_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic [4:0]    resp_rd_o;
  logic          resp_store_o;
  logic [1:0]    resp_fault_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [1:0]    mem_size_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_store_i,
    input  req_funct3_i, req_addr_i,
    input  req_wdata_i, req_rd_i,
    output req_ready_o,
    output resp_valid_o, resp_rdata_o,
    output resp_rd_o, resp_store_o,
    output resp_fault_o,
    input  resp_ready_i,
    output mem_read_o, mem_write_o,
    output mem_size_o, mem_addr_o,
    output mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output req_valid_i, req_store_i,
    output req_funct3_i, req_addr_i,
    output req_wdata_i, req_rd_i,
    input  req_ready_o,
    input  resp_valid_o, resp_rdata_o,
    input  resp_rd_o, resp_store_o,
    input  resp_fault_o,
    output resp_ready_i,
    input  mem_read_o, mem_write_o,
    input  mem_size_o, mem_addr_o,
    input  mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/slsu_check.sv
// Request legality check: funct3, then
// alignment, then bounds.
module slsu_check
  import slsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  output lsu_fault_e            fault
);

  logic illegal;
  logic misalign;
  logic oob;

  // funct3 legality; unsigned forms are load-only
  always_comb begin
    illegal = 1'b0;
    unique case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = store;
      default:          illegal = 1'b1;
    endcase
  end

  // natural alignment by access size
  always_comb begin
    misalign = 1'b0;
    unique case (funct3[1:0])
      MEM_SIZE_H: misalign = addr[0];
      MEM_SIZE_W: misalign = |addr[1:0];
      default:    misalign = 1'b0;
    endcase
  end

  // any access starting in the last 3 bytes
  // is rejected regardless of size
  assign oob =
    addr >= DATA_WIDTH'(MEM_SIZE - 3);

  // first failing check wins
  always_comb begin
    if (illegal)
      fault = FLT_ILLEGAL;
    else if (misalign)
      fault = FLT_MISALIGN;
    else if (oob)
      fault = FLT_BOUNDS;
    else
      fault = FLT_NONE;
  end

endmodule

// File: rtl/slsu_ctrl.sv
// Load/store unit: one request at a time,
// single-cycle memory access, registered reply.
module slsu_ctrl
  import slsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DW,
  parameter int MEM_SIZE   = LSU_MEM_BYTES
) (
  input logic   clk,
  input logic   rst_n,
  slsu_if.slave bus
);

  lsu_state_e            state;
  lsu_req_t              req_q;
  lsu_fault_e            chk_fault;
  lsu_fault_e            fault_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [1:0]            mem_size_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  accept;

  slsu_check #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_check (
    .store (bus.req_store_i),
    .funct3(bus.req_funct3_i),
    .addr  (bus.req_addr_i),
    .fault (chk_fault)
  );

  assign accept =
    bus.req_valid_i && (state == IDLE);

  // memory already sign-extends; only the
  // unsigned loads need their upper bits cleared
  always_comb begin
    ext_rdata = bus.mem_rdata_i;
    unique case (1'b1)
      req_q.funct3 == F3_BU:
        ext_rdata = {{(DATA_WIDTH-8){1'b0}},
                     bus.mem_rdata_i[7:0]};
      req_q.funct3 == F3_HU:
        ext_rdata = {{(DATA_WIDTH-16){1'b0}},
                     bus.mem_rdata_i[15:0]};
      default: ;
    endcase
  end

  // FSM with request latch, memory strobes
  // and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_q        <= '0;
      fault_q      <= FLT_NONE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_size_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_q.store  <= bus.req_store_i;
            req_q.funct3 <= bus.req_funct3_i;
            req_q.rd     <= bus.req_rd_i;
            fault_q      <= chk_fault;
            if (chk_fault != FLT_NONE) begin
              resp_rdata_q <= '0;
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end else begin
              mem_read_q  <= !bus.req_store_i;
              mem_write_q <= bus.req_store_i;
              mem_size_q  <= bus.req_funct3_i[1:0];
              mem_addr_q  <= bus.req_addr_i;
              mem_wdata_q <= bus.req_wdata_i;
              state       <= ACCESS;
            end
          end
        end
        ACCESS: begin
          resp_rdata_q <= req_q.store ?
                          '0 : ext_rdata;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (state == IDLE);
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_rd_o    = req_q.rd;
  assign bus.resp_store_o = req_q.store;
  assign bus.resp_fault_o = fault_q;
  assign bus.mem_read_o   = mem_read_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_size_o   = mem_size_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_slsu_ctrl.sv
// Bench for slsu_ctrl: byte-array memory,
// reference model queue, per-cycle compare.
module tb_slsu_ctrl;
  import slsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slsu_if #(.DW(32)) bus ();

  slsu_ctrl #(
    .DATA_WIDTH(32),
    .MEM_SIZE  (1024)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [1:0]  flt;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  logic bp = 1'b0;
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  exp_t q [$];
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_fault = '0;
  logic [31:0] last_exp = '0;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h cyc %0d",
               nm, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired cyc %0d",
             nm, cyc);
  endtask

  // data memory, sign-extending like sdatamem
  function automatic logic [31:0] sdm_read(
      input logic [31:0] a, input logic [1:0] sz);
    logic [9:0] i;
    i = a[9:0];
    case (sz)
      2'b00: return {{24{mem[i][7]}}, mem[i]};
      2'b01: return {{16{mem[i+10'd1][7]}},
                     mem[i+10'd1], mem[i]};
      default: return {mem[i+10'd3], mem[i+10'd2],
                       mem[i+10'd1], mem[i]};
    endcase
  endfunction

  always @(bus.mem_addr_o or bus.mem_size_o
           or bus.mem_read_o)
    bus.mem_rdata_i = sdm_read(bus.mem_addr_o,
                               bus.mem_size_o);

  always @(posedge clk) begin
    if (bus.mem_write_o) begin
      for (int k = 0; k < 4; k++)
        if (k < (1 << bus.mem_size_o))
          mem[(int'(bus.mem_addr_o[9:0]) + k) % 1024] =
            bus.mem_wdata_o[8*k +: 8];
    end
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus.resp_ready_i = bp ? 1'b0 :
                       ($urandom_range(0, 3) != 0);
  end

  // reference rules
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 :
           (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] ref_fault(
      input logic st, input logic [2:0] f3,
      input logic [31:0] a);
    logic legal;
    legal = st ? (f3 <= 3'd2) :
                 (f3 inside {3'd0, 3'd1, 3'd2,
                             3'd4, 3'd5});
    if (!legal) return 2'b11;
    if (a % nbytes(f3) != 0) return 2'b01;
    if (a > 32'd1020) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(
      input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    v = '0;
    for (int k = 0; k < n; k++)
      v = v | (32'(ref_mem[int'(a) + k]) << (8*k));
    if (!f3[2] && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3,
                           input logic [31:0] a,
                           input logic [31:0] wd);
    for (int k = 0; k < nbytes(f3); k++)
      ref_mem[int'(a) + k] = wd[8*k +: 8];
  endtask

  // per-cycle compare against the model queue
  always @(negedge clk) begin : cmp
    exp_t e;
    logic has;
    logic mact;
    logic rexp;
    if (rst_n) begin
      has = q.size() > 0;
      if (has) e = q[0];
      chk("req_ready", 128'(bus.req_ready_o),
          128'(!has));
      mact = has && e.flt == 2'b00 && cyc == e.acc;
      if (bus.mem_write_o) wr_cnt++;
      chk("mem_ctl",
          {bus.mem_read_o, bus.mem_write_o,
           bus.mem_size_o, bus.mem_addr_o,
           bus.mem_wdata_o},
          mact ? {!e.st, e.st, e.f3[1:0], e.a, e.wd}
               : 68'h0);
      rexp = has &&
        cyc >= e.acc + ((e.flt != 2'b00) ? 0 : 1);
      chk("resp_valid", 128'(bus.resp_valid_o),
          128'(rexp));
      if (rexp && bus.resp_valid_o) begin
        chk("resp_data",
            {bus.resp_rd_o, bus.resp_store_o,
             bus.resp_fault_o, bus.resp_rdata_o},
            {e.rd, e.st, e.flt, e.rdata});
        if (bus.resp_ready_i) begin
          last_rdata = bus.resp_rdata_o;
          last_fault = bus.resp_fault_o;
          if (e.st && e.flt == 2'b00)
            ref_store(e.f3, e.a, e.wd);
          void'(q.pop_front());
        end
      end
    end
  end

  // called at posedge+1; returns at accept edge+1
  task automatic issue(input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [4:0] rd);
    exp_t e;
    int t;
    t = 0;
    while (!bus.req_ready_o) begin
      bus.req_valid_i  = 1'b1;
      bus.req_store_i  = 1'($urandom);
      bus.req_funct3_i = 3'($urandom);
      bus.req_addr_i   = $urandom;
      bus.req_wdata_i  = $urandom;
      bus.req_rd_i     = 5'($urandom);
      @(posedge clk);
      #1;
      t++;
      if (t > 100) begin
        fail_now("issue_wait");
        bus.req_valid_i = 1'b0;
        q.delete();
        return;
      end
    end
    bus.req_valid_i  = 1'b1;
    bus.req_store_i  = st;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = a;
    bus.req_wdata_i  = wd;
    bus.req_rd_i     = rd;
    e.st = st;
    e.f3 = f3;
    e.a = a;
    e.wd = wd;
    e.rd = rd;
    e.flt = ref_fault(st, f3, a);
    e.rdata = (st || e.flt != 2'b00) ?
              32'h0 : ref_load(f3, a);
    @(posedge clk);
    #1;
    e.acc = cyc;
    q.push_back(e);
    last_exp = e.rdata;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      fail_now("wait_idle");
      q.delete();
    end
  endtask

  task automatic lit(input string nm,
                     input logic [31:0] v,
                     input logic [1:0] f);
    chk({nm, "_model"}, 128'(last_exp), 128'(v));
    chk(nm, {last_fault, last_rdata}, {f, v});
  endtask

  task automatic check_reset(input string nm);
    chk(nm,
        {bus.req_ready_o, bus.resp_valid_o,
         bus.resp_rdata_o, bus.resp_rd_o,
         bus.resp_store_o, bus.resp_fault_o,
         bus.mem_read_o, bus.mem_write_o,
         bus.mem_size_o, bus.mem_addr_o,
         bus.mem_wdata_o},
        {1'b1, 109'h0});
  endtask

  task automatic poke(input int a,
                      input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      mem[a+k] = w[8*k +: 8];
      ref_mem[a+k] = w[8*k +: 8];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [2:0] lg [5];
    logic st;
    logic [2:0] f3;
    logic [31:0] a;
    lg = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.req_valid_i  = 1'b0;
    bus.req_store_i  = 1'b0;
    bus.req_funct3_i = '0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.req_rd_i     = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    poke(32'h10, 32'h8000_00FF);
    poke(32'h40, 32'h0BAD_F00D);
    #2;
    check_reset("reset_state");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, F3_W, 32'h10, 32'h0, 5'd1);
    wait_idle();
    lit("lw_10", 32'h8000_00FF, 2'b00);
    issue(1'b0, F3_BU, 32'h10, 32'h0, 5'd2);
    wait_idle();
    lit("lbu_10", 32'h0000_00FF, 2'b00);
    issue(1'b0, F3_B, 32'h10, 32'h0, 5'd3);
    wait_idle();
    lit("lb_10", 32'hFFFF_FFFF, 2'b00);
    issue(1'b0, F3_HU, 32'h12, 32'h0, 5'd4);
    wait_idle();
    lit("lhu_12", 32'h0000_8000, 2'b00);

    w0 = wr_cnt;
    issue(1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, 5'd5);
    wait_idle();
    chk("sw_pulse", 128'(wr_cnt - w0), 128'd1);
    lit("sw_resp", 32'h0, 2'b00);
    issue(1'b0, F3_W, 32'h20, 32'h0, 5'd6);
    wait_idle();
    lit("lw_20", 32'hDEAD_BEEF, 2'b00);

    issue(1'b0, F3_W, 32'h21, 32'h0, 5'd7);
    wait_idle();
    lit("lw_mis", 32'h0, 2'b01);
    w0 = wr_cnt;
    issue(1'b1, F3_B, 32'h3FD, 32'hAA, 5'd8);
    wait_idle();
    chk("sb_oob_nowr", 128'(wr_cnt - w0), 128'd0);
    lit("sb_oob", 32'h0, 2'b10);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 5'd9);
    wait_idle();
    lit("ld_ill", 32'h0, 2'b11);

    @(negedge clk);
    bp = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, F3_W, 32'h10, 32'h0, 5'd10);
    fork
      begin
        repeat (6) begin
          @(posedge clk);
          #1;
        end
        chk("bp_hold",
            {bus.resp_valid_o, bus.req_ready_o},
            2'b10);
        @(negedge clk);
        bp = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        issue(1'b0, F3_BU, 32'h13, 32'h0, 5'd11);
      end
    join
    wait_idle();
    lit("bp_next", 32'h0000_0080, 2'b00);

    issue(1'b1, F3_W, 32'h40, 32'h1234, 5'd12);
    chk("rst_pre", 128'(bus.mem_write_o), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, F3_W, 32'h40, 32'h0, 5'd13);
    wait_idle();
    lit("rst_nowrite", 32'h0BAD_F00D, 2'b00);

    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ?
           3'($urandom) : lg[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0: a = {22'h0, 8'($urandom), 2'b00};
        1: a = 32'($urandom_range(0, 1023));
        2: a = 32'($urandom_range(1012, 1027));
        default: a = $urandom;
      endcase
      issue(st, f3, a, $urandom, 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
